mem_bus_arbiter: RTL and testbench

//  Two-master round-robin arbiter placed in front of memory_controller, sharing the single

---
 rtl/mem_bus_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Two-master round-robin arbiter that shares the single core-side memory bus
//   in front of memory_controller. Master 0 is the core. Master 1 is a second
//   requester such as DMA or debug. Each master sees the same busy-rise /
//   busy-fall handshake the core already uses. Transactions are atomic: once a
//   master is granted, the other master has no effect on the bus until the
//   granted transfer has released.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   mN_rd_en, mN_wr_en    master N read / write request (N = 0, 1)
//   mN_byte_en            master N byte enables
//   mN_addr, mN_wr_data   master N address and write data
//   mN_rd_data            master N read data, registered at completion
//   mN_busy               master N busy (rises on request, falls on release)
//   mem_rd_en, mem_wr_en  request strobes to memory_controller
//   mem_byte_en           byte enables to memory_controller
//   mem_addr, wr_data     address and write data to memory_controller
//   rd_data, mem_busy     read data and busy from memory_controller
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_NUM  = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 m0_rd_en,
  input  logic                 m0_wr_en,
  input  logic [BYTE_NUM-1:0]  m0_byte_en,
  input  logic [DATA_SIZE-1:0] m0_addr,
  input  logic [DATA_SIZE-1:0] m0_wr_data,
  output logic [DATA_SIZE-1:0] m0_rd_data,
  output logic                 m0_busy,

  input  logic                 m1_rd_en,
  input  logic                 m1_wr_en,
  input  logic [BYTE_NUM-1:0]  m1_byte_en,
  input  logic [DATA_SIZE-1:0] m1_addr,
  input  logic [DATA_SIZE-1:0] m1_wr_data,
  output logic [DATA_SIZE-1:0] m1_rd_data,
  output logic                 m1_busy,

  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BYTE_NUM-1:0]  mem_byte_en,
  output logic [DATA_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  input  logic [DATA_SIZE-1:0] rd_data,
  input  logic                 mem_busy
);

  // The access-phase watchdog is a 4-bit counter.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_grant;
  logic                 w_nextGrant;
  logic                 r_lastGrant;
  logic                 w_nextLastGrant;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_nextCount;
  logic                 w_capture;
  logic [DATA_SIZE-1:0] r_m0RdData;
  logic [DATA_SIZE-1:0] r_m1RdData;

  logic                 w_req0;
  logic                 w_req1;
  logic                 w_reqGrant;
  logic                 w_selRdEn;
  logic                 w_selWrEn;
  logic [BYTE_NUM-1:0]  w_selByteEn;
  logic [DATA_SIZE-1:0] w_selAddr;
  logic [DATA_SIZE-1:0] w_selWrData;

  // A master is requesting whenever either of its strobes is high.
  assign w_req0 = m0_rd_en | m0_wr_en;
  assign w_req1 = m1_rd_en | m1_wr_en;

  // Select the granted master's bus fields. Only the granted master ever
  // reaches the memory side, so the other master cannot disturb a transfer.
  always_comb begin
    w_reqGrant  = w_req0;
    w_selRdEn   = m0_rd_en;
    w_selWrEn   = m0_wr_en;
    w_selByteEn = m0_byte_en;
    w_selAddr   = m0_addr;
    w_selWrData = m0_wr_data;
    if (r_grant) begin
      w_reqGrant  = w_req1;
      w_selRdEn   = m1_rd_en;
      w_selWrEn   = m1_wr_en;
      w_selByteEn = m1_byte_en;
      w_selAddr   = m1_addr;
      w_selWrData = m1_wr_data;
    end
  end

  // State, grant and watchdog registers. Reset leaves last_grant pointing at
  // master 1 so that the core wins the very first contested arbitration.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_count     <= '0;
    end else begin
      r_state     <= w_nextState;
      r_grant     <= w_nextGrant;
      r_lastGrant <= w_nextLastGrant;
      r_count     <= w_nextCount;
    end
  end

  // Next-state and bus output logic.
  // IDLE arbitrates; a contested request goes to the master that did not win
  // last time. ACCESS waits for the slave to accept (busy rise), may be
  // abandoned by the granted master, and gives up after TIMEOUT cycles. WAIT
  // cannot be abandoned because the slave has already started. RELEASE is the
  // single cycle in which the granted master sees its busy fall; the strobes
  // are dropped there so the slave does not see a second request.
  always_comb begin
    w_nextState     = r_state;
    w_nextGrant     = r_grant;
    w_nextLastGrant = r_lastGrant;
    w_nextCount     = r_count;
    w_capture       = 1'b0;
    mem_rd_en       = 1'b0;
    mem_wr_en       = 1'b0;
    mem_byte_en     = '0;
    mem_addr        = '0;
    wr_data         = '0;

    case (r_state)
      IDLE: begin
        w_nextCount = '0;
        if (w_req0 || w_req1) begin
          if (w_req0 && w_req1) begin
            w_nextGrant = ~r_lastGrant;
          end else begin
            w_nextGrant = w_req1;
          end
          w_nextLastGrant = w_nextGrant;
          w_nextState     = ACCESS;
        end
      end

      ACCESS: begin
        mem_rd_en   = w_selRdEn;
        mem_wr_en   = w_selWrEn;
        mem_byte_en = w_selByteEn;
        mem_addr    = w_selAddr;
        wr_data     = w_selWrData;
        if (mem_busy) begin
          w_nextState = WAIT;
          w_nextCount = '0;
        end else if (!w_reqGrant) begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end else if (r_count == LAST_COUNT) begin
          w_nextState = RELEASE;
          w_nextCount = '0;
          w_capture   = 1'b1;
        end else begin
          w_nextCount = r_count + CNT_W'(1);
        end
      end

      WAIT: begin
        mem_rd_en   = w_selRdEn;
        mem_wr_en   = w_selWrEn;
        mem_byte_en = w_selByteEn;
        mem_addr    = w_selAddr;
        wr_data     = w_selWrData;
        if (!mem_busy) begin
          w_nextState = RELEASE;
          w_capture   = 1'b1;
        end
      end

      RELEASE: begin
        mem_byte_en = w_selByteEn;
        mem_addr    = w_selAddr;
        wr_data     = w_selWrData;
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Read data capture. The slave's read bus is latched on every completion,
  // writes included, and held until that master's next completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m0RdData <= '0;
      r_m1RdData <= '0;
    end else if (w_capture) begin
      if (r_grant) begin
        r_m1RdData <= rd_data;
      end else begin
        r_m0RdData <= rd_data;
      end
    end
  end

  assign m0_rd_data = r_m0RdData;
  assign m1_rd_data = r_m1RdData;

  // Busy follows the request and drops only in that master's own RELEASE
  // cycle, so a master that is kept waiting simply stays busy. It depends on
  // memory-side inputs only through the registered state.
  assign m0_busy = w_req0 & ~((r_state == RELEASE) & ~r_grant);
  assign m1_busy = w_req1 & ~((r_state == RELEASE) &  r_grant);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed and randomized bench for mem_bus_arbiter. A small behavioural
// memory controller sits on the memory side. It answers a request by raising
// busy one cycle later, holding it for a few cycles and then completing the
// access. A reference word array predicts every read result in transaction
// order.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int DS = 32;
  localparam int BN = 4;
  localparam int TIMEOUT = 15;
  localparam logic [DS-1:0] TIMEOUT_DATA = 32'h5A5A_1234;

  logic          clock = 1'b0;
  logic          reset;

  logic          m0_rd_en, m0_wr_en;
  logic [BN-1:0] m0_byte_en;
  logic [DS-1:0] m0_addr, m0_wr_data, m0_rd_data;
  logic          m0_busy;
  logic          m1_rd_en, m1_wr_en;
  logic [BN-1:0] m1_byte_en;
  logic [DS-1:0] m1_addr, m1_wr_data, m1_rd_data;
  logic          m1_busy;
  logic          mem_rd_en, mem_wr_en;
  logic [BN-1:0] mem_byte_en;
  logic [DS-1:0] mem_addr, wr_data, rd_data;
  logic          mem_busy;

  int checks = 0;
  int failures = 0;

  logic [DS-1:0] refRam [16];

  // Behavioural slave controls.
  bit noBusy = 1'b0;
  bit randLen = 1'b0;
  int slvLen = 2;
  logic [DS-1:0] slvRam [16];
  int slvState;
  int slvCnt;

  mem_bus_arbiter #(.DATA_SIZE(DS), .BYTE_NUM(BN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_byte_en(m0_byte_en),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data),
    .m0_busy(m0_busy),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_byte_en(m1_byte_en),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data),
    .m1_busy(m1_busy),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en),
    .mem_addr(mem_addr), .wr_data(wr_data), .rd_data(rd_data),
    .mem_busy(mem_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [DS-1:0] initWord(input int i);
    return 32'h1357_0011 + i * 32'h0001_0203;
  endfunction

  function automatic logic [DS-1:0] merge(input logic [DS-1:0] old,
                                          input logic [DS-1:0] data,
                                          input logic [BN-1:0] be);
    logic [DS-1:0] w;
    w = old;
    for (int b = 0; b < BN; b++) begin
      if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    return w;
  endfunction

  // Memory controller model: accept, stay busy, complete, then wait for the
  // strobes to drop before accepting again.
  always @(posedge clock) begin
    if (reset) begin
      mem_busy <= 1'b0;
      rd_data  <= '0;
      slvState <= 0;
      slvCnt   <= 0;
      for (int i = 0; i < 16; i++) slvRam[i] <= initWord(i);
    end else begin
      case (slvState)
        0: begin
          if (noBusy) begin
            rd_data <= TIMEOUT_DATA;
          end else if (mem_rd_en || mem_wr_en) begin
            mem_busy <= 1'b1;
            slvCnt   <= randLen ? int'($urandom_range(0, 2)) : slvLen - 1;
            slvState <= 1;
          end
        end
        1: begin
          if (slvCnt == 0) begin
            mem_busy <= 1'b0;
            rd_data  <= slvRam[mem_addr[5:2]];
            if (mem_wr_en)
              slvRam[mem_addr[5:2]] <= merge(slvRam[mem_addr[5:2]], wr_data, mem_byte_en);
            slvState <= 2;
          end else begin
            slvCnt <= slvCnt - 1;
          end
        end
        default: begin
          if (!(mem_rd_en || mem_wr_en)) slvState <= 0;
        end
      endcase
    end
  end

  // Drive one master's request fields.
  task automatic applyStimulus(input int m, input logic rd, input logic wr,
                               input logic [BN-1:0] be, input logic [DS-1:0] addr,
                               input logic [DS-1:0] data);
    if (m == 0) begin
      m0_rd_en = rd; m0_wr_en = wr; m0_byte_en = be; m0_addr = addr; m0_wr_data = data;
    end else begin
      m1_rd_en = rd; m1_wr_en = wr; m1_byte_en = be; m1_addr = addr; m1_wr_data = data;
    end
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic getBusy(input int m);
    return (m == 0) ? m0_busy : m1_busy;
  endfunction

  function automatic logic [DS-1:0] getRd(input int m);
    return (m == 0) ? m0_rd_data : m1_rd_data;
  endfunction

  // Wait, with a cycle budget, for master m's busy to fall while it requests.
  task automatic waitDone(input int m, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (getBusy(m) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Randomized traffic from one master; read results predicted from refRam.
  task automatic masterRun(input int m);
    bit ok;
    int gap, idx;
    bit isWr;
    logic [DS-1:0] data;
    logic [BN-1:0] be;
    for (int t = 0; t < 8; t++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        applyStimulus(m, 1'b0, 1'b0, '0, '0, '0);
        repeat (gap) @(negedge clock);
      end
      isWr = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 15);
      data = $urandom;
      be   = BN'($urandom_range(1, 15));
      applyStimulus(m, !isWr, isWr, be, 32'h100 | DS'(idx << 2), data);
      waitDone(m, ok);
      checkOutput($sformatf("rand_m%0d_done", m), 64'(ok), 64'd1);
      if (!ok) break;
      if (isWr) refRam[idx] = merge(refRam[idx], data, be);
      else checkOutput($sformatf("rand_m%0d_rd", m), 64'(getRd(m)), 64'(refRam[idx]));
    end
    applyStimulus(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    bit ok;
    int expWinner, winner, cycles, enCount;

    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 16; i++) refRam[i] = initWord(i);
    repeat (3) @(negedge clock);

    // Reset state
    checkOutput("rst_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("rst_wr_en", 64'(mem_wr_en), 64'd0);
    checkOutput("rst_m0_busy", 64'(m0_busy), 64'd0);
    checkOutput("rst_m1_busy", 64'(m1_busy), 64'd0);
    checkOutput("rst_m0_rd", 64'(m0_rd_data), 64'd0);
    checkOutput("rst_m1_rd", 64'(m1_rd_data), 64'd0);
    reset = 1'b0;

    // Contested first request: core read wins, DMA write waits.
    $display("[TB] simultaneous m0 read / m1 write");
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h104, '0);
    applyStimulus(1, 1'b0, 1'b1, 4'hF, 32'h108, 32'hDEAD_BEEF);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checkOutput("a_grant_m0_addr", 64'(mem_addr), 64'h104);
        checkOutput("a_grant_m0_rd", 64'(mem_rd_en), 64'd1);
      end
      if (!m0_busy) begin
        ok = 1'b1;
        break;
      end
      checkOutput("a_m1_waits", 64'(m1_busy), 64'd1);
      checkOutput("a_m1_no_bus", 64'(mem_wr_en), 64'd0);
    end
    checkOutput("a_m0_done", 64'(ok), 64'd1);
    checkOutput("a_m0_rd", 64'(m0_rd_data), 64'(refRam[1]));
    checkOutput("a_m1_still_busy", 64'(m1_busy), 64'd1);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    waitDone(1, ok);
    checkOutput("a_m1_done", 64'(ok), 64'd1);
    refRam[2] = merge(refRam[2], 32'hDEAD_BEEF, 4'hF);
    checkOutput("a_ram_written", 64'(slvRam[2]), 64'(refRam[2]));
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);

    // Single read with latency check.
    $display("[TB] single m0 read");
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h100, '0);
    #1;
    checkOutput("b_idle_bus", 64'(mem_rd_en), 64'd0);
    @(negedge clock);
    checkOutput("b_latency_rd_en", 64'(mem_rd_en), 64'd1);
    checkOutput("b_latency_addr", 64'(mem_addr), 64'h100);
    waitDone(0, ok);
    checkOutput("b_done", 64'(ok), 64'd1);
    checkOutput("b_rd_data", 64'(m0_rd_data), 64'(refRam[0]));
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);
    checkOutput("b_rd_hold", 64'(m0_rd_data), 64'(refRam[0]));

    // Both masters saturating the bus: winners alternate. The last grant so
    // far went to m0, so m1 goes first.
    $display("[TB] alternating rounds");
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10C, '0);
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h110, '0);
    expWinner = 1;
    for (int r = 0; r < 4; r++) begin
      ok = 1'b0;
      winner = -1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clock);
        if (!m0_busy) begin winner = 0; ok = 1'b1; break; end
        if (!m1_busy) begin winner = 1; ok = 1'b1; break; end
      end
      checkOutput("c_round_done", 64'(ok), 64'd1);
      checkOutput("c_winner", 64'(winner), 64'(expWinner));
      checkOutput("c_loser_busy", 64'(getBusy(1 - expWinner)), 64'd1);
      checkOutput("c_rd_data", 64'(getRd(expWinner)),
                  64'(refRam[expWinner == 0 ? 3 : 4]));
      expWinner = 1 - expWinner;
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);

    // m1 abandons its request before the slave accepts; m0 is served next.
    $display("[TB] m1 abort in ACCESS");
    noBusy = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h114, '0);
    @(negedge clock);
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h118, '0);
    checkOutput("d_m1_granted", 64'(mem_addr), 64'h114);
    @(negedge clock);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);
    checkOutput("d_abort_idle", 64'(mem_rd_en), 64'd0);
    noBusy = 1'b0;
    @(negedge clock);
    checkOutput("d_m0_next_addr", 64'(mem_addr), 64'h118);
    checkOutput("d_m0_next_rd", 64'(mem_rd_en), 64'd1);
    checkOutput("d_m1_rd_kept", 64'(m1_rd_data), 64'(refRam[4]));
    checkOutput("d_m1_not_busy", 64'(m1_busy), 64'd0);
    waitDone(0, ok);
    checkOutput("d_m0_done", 64'(ok), 64'd1);
    checkOutput("d_m0_rd", 64'(m0_rd_data), 64'(refRam[6]));
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);

    // Slave never accepts: release after TIMEOUT cycles of access.
    $display("[TB] access timeout");
    noBusy = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h11C, '0);
    cycles = 0;
    enCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      cycles++;
      if (mem_rd_en) enCount++;
      if (!m0_busy) break;
    end
    checkOutput("e_busy_cycles", 64'(cycles), 64'(TIMEOUT + 1));
    checkOutput("e_access_cycles", 64'(enCount), 64'(TIMEOUT));
    checkOutput("e_rd_capture", 64'(m0_rd_data), 64'(TIMEOUT_DATA));
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    noBusy = 1'b0;
    @(negedge clock);

    // Reset while waiting on the slave.
    $display("[TB] reset during WAIT");
    slvLen = 6;
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h100, '0);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (mem_busy) begin ok = 1'b1; break; end
    end
    checkOutput("f_slave_busy", 64'(ok), 64'd1);
    @(negedge clock);
    checkOutput("f_wait_rd_en", 64'(mem_rd_en), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("f_rst_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("f_rst_wr_en", 64'(mem_wr_en), 64'd0);
    checkOutput("f_rst_m0_rd", 64'(m0_rd_data), 64'd0);
    checkOutput("f_rst_m1_rd", 64'(m1_rd_data), 64'd0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b0;
    slvLen = 2;
    for (int i = 0; i < 16; i++) refRam[i] = initWord(i);
    @(negedge clock);

    // Random traffic from both masters.
    $display("[TB] random traffic");
    randLen = 1'b1;
    fork
      masterRun(0);
      masterRun(1);
    join
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("g_ram_%0d", i), 64'(slvRam[i]), 64'(refRam[i]));
    end
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
